// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: state encodings,
// the op bit that selects logic operations, and the ALU slice width.
package alu_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int OP_LOGIC_BIT = 2;
  localparam int NIBBLE_W     = 4;

  // Index width that stays legal when the sequencer is built for a single nibble.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_nibble_mux.sv
// Picks nibble [index] out of both wide operands for the current ALU pass.
module alu_seq_nibble_mux
  import alu_sequencer_pkg::*;
#(
  parameter int NIBBLES = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NIBBLES*NIBBLE_W-1:0] a,
  input  logic [NIBBLES*NIBBLE_W-1:0] b,
  input  logic [IDX_W-1:0]            index,
  output logic [NIBBLE_W-1:0]         a_nib,
  output logic [NIBBLE_W-1:0]         b_nib
);

  // Nibble select; an out-of-range index yields zero.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (index == IDX_W'(i)) begin
        a_nib = a[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b[i*NIBBLE_W +: NIBBLE_W];
      end else begin
        a_nib = a_nib;
        b_nib = b_nib;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Runs a 4-bit ALU over NIBBLES*4-bit operands, one nibble per cycle, LSB first.
// Optional completed-op counter enabled by defining ALU_SEQUENCER_STATS_EN.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NIBBLES = 2,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [NIBBLES*NIBBLE_W-1:0] cmd_a,
  input  logic [NIBBLES*NIBBLE_W-1:0] cmd_b,
  input  logic                        cmd_cin,
  input  logic                        cmd_wide,
  output logic [3:0]                  alu_a,
  output logic [3:0]                  alu_b,
  output logic                        alu_cin,
  output logic [2:0]                  alu_op,
  input  logic [3:0]                  alu_r,
  input  logic                        alu_zero,
  input  logic                        alu_carry,
  input  logic                        alu_sign,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [NIBBLES*NIBBLE_W-1:0] res_data,
  output logic                        res_zero,
  output logic                        res_carry,
  output logic                        res_sign,
  output logic [CNT_W-1:0]            op_count
);

  localparam int W     = NIBBLES * NIBBLE_W;
  localparam int IDX_W = idx_width(NIBBLES);

  logic [1:0]       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [2:0]       op_r;
  logic             wide_r;
  logic             cin_r;
  logic             carry_r;
  logic [W-1:0]     res_data_r;
  logic             res_zero_r;
  logic             res_carry_r;
  logic             res_sign_r;

  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic             last_s;
  logic [W-1:0]     next_data_s;
  logic             unused_zero_s;

  // The ALU recomputes zero per nibble only; the wide zero flag is derived here.
  assign unused_zero_s = alu_zero;

  alu_seq_nibble_mux #(
    .NIBBLES (NIBBLES),
    .IDX_W   (IDX_W)
  ) u_nibble_mux (
    .a     (a_r),
    .b     (b_r),
    .index (idx_r),
    .a_nib (a_nib_s),
    .b_nib (b_nib_s)
  );

  assign last_s    = wide_r ? (idx_r == IDX_W'(NIBBLES - 1)) : (idx_r == {IDX_W{1'b0}});
  assign cmd_ready = (state_r == ST_IDLE);
  assign res_valid = (state_r == ST_DONE);
  assign res_data  = res_data_r;
  assign res_zero  = res_zero_r;
  assign res_carry = res_carry_r;
  assign res_sign  = res_sign_r;

  // ALU drive comes only from latched state; logic ops never chain carries.
  always_comb begin
    if (state_r == ST_PASS) begin
      alu_a   = a_nib_s;
      alu_b   = b_nib_s;
      alu_op  = op_r;
      alu_cin = ((idx_r == {IDX_W{1'b0}}) || op_r[OP_LOGIC_BIT]) ? cin_r : carry_r;
    end else begin
      alu_a   = 4'h0;
      alu_b   = 4'h0;
      alu_op  = 3'b000;
      alu_cin = 1'b0;
    end
  end

  // Result image with the current pass's nibble merged in.
  always_comb begin
    next_data_s = res_data_r;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_r == IDX_W'(i)) begin
        next_data_s[i*NIBBLE_W +: NIBBLE_W] = alu_r;
      end else begin
        next_data_s[i*NIBBLE_W +: NIBBLE_W] = res_data_r[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  // Sequencer state, operand latch and result assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      op_r        <= 3'b000;
      wide_r      <= 1'b0;
      cin_r       <= 1'b0;
      carry_r     <= 1'b0;
      res_data_r  <= {W{1'b0}};
      res_zero_r  <= 1'b0;
      res_carry_r <= 1'b0;
      res_sign_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            a_r        <= cmd_a;
            b_r        <= cmd_b;
            op_r       <= cmd_op;
            wide_r     <= cmd_wide;
            cin_r      <= cmd_cin;
            idx_r      <= {IDX_W{1'b0}};
            res_data_r <= {W{1'b0}};
            state_r    <= ST_PASS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PASS: begin
          res_data_r <= next_data_s;
          carry_r    <= alu_carry;
          if (last_s) begin
            res_zero_r  <= (next_data_s == {W{1'b0}});
            res_carry_r <= alu_carry & ~op_r[OP_LOGIC_BIT];
            res_sign_r  <= alu_sign;
            state_r     <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQUENCER_STATS_EN
  logic [CNT_W-1:0] op_count_r;

  // Completed-op counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_DONE) && res_ready) begin
      op_count_r <= op_count_r + CNT_W'(1);
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign op_count = op_count_r;
`else
  assign op_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU and a result scoreboard.
module tb_alu_sequencer;

  localparam int NIBBLES = 2;
  localparam int CNT_W   = 8;
  localparam int W       = NIBBLES * 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         zero;
    logic         carry;
    logic         sign;
    logic [3:0]   lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready, cmd_cin, cmd_wide;
  logic [2:0]       cmd_op;
  logic [W-1:0]     cmd_a, cmd_b;
  logic [3:0]       alu_a, alu_b, alu_r;
  logic             alu_cin, alu_zero, alu_carry, alu_sign;
  logic [2:0]       alu_op;
  logic             res_valid, res_ready, res_zero, res_carry, res_sign;
  logic [W-1:0]     res_data;
  logic [CNT_W-1:0] op_count;

  logic [4:0]       alu_sum;
  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [7:0]       exp_cnt = 8'd0;

  always #5 clk = ~clk;

  alu_sequencer #(.NIBBLES(NIBBLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_wide(cmd_wide),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_carry(res_carry), .res_sign(res_sign),
    .op_count(op_count)
  );

  // Reference 4-bit ALU; logic ops deliberately raise carry so masking is visible.
  always_comb begin
    alu_sum   = 5'd0;
    alu_r     = 4'h0;
    alu_carry = 1'b0;
    case (alu_op)
      3'b001:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
      3'b100:  alu_sum = {1'b1, alu_a & alu_b};
      3'b101:  alu_sum = {1'b1, alu_a | alu_b};
      3'b110:  alu_sum = {1'b1, alu_a ^ alu_b};
      3'b111:  alu_sum = {1'b1, ~(alu_a & alu_b)};
      default: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
    endcase
    alu_r     = alu_sum[3:0];
    alu_carry = alu_sum[4];
    alu_sign  = alu_r[3];
    alu_zero  = (alu_r == 4'h0);
  end

  function automatic exp_t model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                 logic cin, logic wide);
    exp_t e;
    int n;
    logic [W:0] sum;
    logic [W-1:0] mask, bb, r;
    n = wide ? NIBBLES : 1;
    mask = '0;
    for (int i = 0; i < 4 * n; i++) mask[i] = 1'b1;
    if (!op[2]) begin
      bb = (op == 3'b001) ? ~b : b;
      sum = {1'b0, a & mask} + {1'b0, bb & mask} + {{W{1'b0}}, cin};
      e.data = sum[W-1:0] & mask;
      e.carry = sum[4*n];
    end else begin
      case (op[1:0])
        2'b00:   r = a & b;
        2'b01:   r = a | b;
        2'b10:   r = a ^ b;
        default: r = ~(a & b);
      endcase
      e.data = r & mask;
      e.carry = 1'b0;
    end
    e.zero = (e.data == '0);
    e.sign = e.data[4*n-1];
    e.lat = 4'(n);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_count();
`ifdef ALU_SEQUENCER_STATS_EN
    return exp_cnt;
`else
    return 8'd0;
`endif
  endfunction

  // Presents one command, queues its expected result, returns one step after acceptance.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic wide);
    int cyc;
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("send_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_wide = wide; cmd_valid = 1'b1;
    sb.push_back(model(op, a, b, cin, wide));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = ~a; cmd_b = ~b;
  endtask

  // Waits for the result, compares against the scoreboard, optionally stalls, then accepts.
  task automatic recv(input string tag, input int pre, input int hold);
    int cyc;
    exp_t e;
    cyc = pre;
    while (res_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    e = sb.pop_front();
    chk({tag, ".lat"}, cyc, {28'd0, e.lat});
    chk({tag, ".data"}, {24'd0, res_data}, {24'd0, e.data});
    chk({tag, ".zero"}, {31'd0, res_zero}, {31'd0, e.zero});
    chk({tag, ".carry"}, {31'd0, res_carry}, {31'd0, e.carry});
    chk({tag, ".sign"}, {31'd0, res_sign}, {31'd0, e.sign});
    for (int k = 0; k < hold; k++) begin
      cmd_valid = 1'b1;
      cmd_a = W'($urandom);
      @(posedge clk); #1;
      chk({tag, ".bp_valid"}, {31'd0, res_valid}, 32'd1);
      chk({tag, ".bp_ready"}, {31'd0, cmd_ready}, 32'd0);
      chk({tag, ".bp_data"}, {24'd0, res_data}, {24'd0, e.data});
      chk({tag, ".bp_flags"}, {29'd0, res_zero, res_carry, res_sign},
          {29'd0, e.zero, e.carry, e.sign});
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_cnt++;
    chk({tag, ".post_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, ".post_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, ".op_count"}, {24'd0, op_count}, {24'd0, exp_count()});
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = 3'b000; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_wide = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst.res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst.res_data", {24'd0, res_data}, 32'd0);
    chk("rst.flags", {29'd0, res_zero, res_carry, res_sign}, 32'd0);
    chk("rst.alu", {20'd0, alu_a, alu_b, alu_cin, alu_op}, 32'd0);
    chk("rst.op_count", {24'd0, op_count}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Wide add 3A + 0F with per-pass ALU drive checks.
    send(3'b000, 8'h3A, 8'h0F, 1'b0, 1'b1);
    chk("add.p0_a", {28'd0, alu_a}, 32'hA);
    chk("add.p0_b", {28'd0, alu_b}, 32'hF);
    chk("add.p0_cin", {31'd0, alu_cin}, 32'd0);
    chk("add.p0_op", {29'd0, alu_op}, 32'd0);
    chk("add.busy", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("add.p1_a", {28'd0, alu_a}, 32'h3);
    chk("add.p1_cin", {31'd0, alu_cin}, 32'd1);
    recv("add", 1, 0);

    send(3'b000, 8'hFF, 8'h01, 1'b0, 1'b1);
    recv("wrap", 0, 0);

    // Logic op: cin passes straight through on every nibble.
    send(3'b110, 8'hC3, 8'h5A, 1'b1, 1'b1);
    chk("xor.p0_cin", {31'd0, alu_cin}, 32'd1);
    @(posedge clk); #1;
    chk("xor.p1_cin", {31'd0, alu_cin}, 32'd1);
    chk("xor.p1_op", {29'd0, alu_op}, 32'd6);
    recv("xor", 1, 0);

    send(3'b000, 8'hF7, 8'hF1, 1'b0, 1'b0);
    chk("narrow.p0_a", {28'd0, alu_a}, 32'h7);
    recv("narrow", 0, 0);

    send(3'b001, 8'h12, 8'h34, 1'b1, 1'b1);
    recv("bp_sub", 0, 5);

    // Reset while a pass is in progress aborts with no result.
    send(3'b000, 8'h55, 8'h22, 1'b0, 1'b1);
    void'(sb.pop_back());
    reset = 1'b0;
    #1;
    chk("midrst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst.res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst.res_data", {24'd0, res_data}, 32'd0);
    chk("midrst.alu_a", {28'd0, alu_a}, 32'd0);
    exp_cnt = 8'd0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst.op_count", {24'd0, op_count}, 32'd0);

    // 259 random ops: counter wraps to 0 at 256 and reads 3 afterwards.
    for (int i = 0; i < 259; i++) begin
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      recv("rand", 0, 0);
      if (i == 255) chk("cnt256", {24'd0, op_count}, {24'd0, exp_count()});
    end
    chk("cnt259", {24'd0, op_count}, {24'd0, exp_count()});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
